// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port RAM (1-cycle registered read) between
// the CPU and a DMA requester.
// - The CPU wins its enable slots.
// - DMA uses idle cycles.
// - A starvation guard steals one CPU slot once DMA has waited STARVE_LIMIT cycles.
// Optional feature macro: RAM_BOUNDS_CHECK_EN. When defined, addresses above
// RAM_TOP are still granted, but writes are dropped and reads return 8'hFF.
module ram_arbiter #(
    parameter int unsigned STARVE_LIMIT = 8,
    parameter logic [15:0] RAM_TOP      = 16'hBFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_en,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_we,
    input  logic [7:0]  cpu_din,
    output logic [7:0]  cpu_dout,
    output logic        cpu_rdy,
    input  logic        dma_req,
    input  logic [15:0] dma_addr,
    input  logic        dma_we,
    input  logic [7:0]  dma_din,
    output logic        dma_ack,
    output logic [7:0]  dma_dout,
    output logic [15:0] ram_addr,
    output logic        ram_we,
    output logic [7:0]  ram_din,
    input  logic [7:0]  ram_dout
);

    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CPU_RSP = 2'd1;
    localparam logic [1:0] ST_DMA_RSP = 2'd2;

`ifdef RAM_BOUNDS_CHECK_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             rsp_read_q, rsp_read_d;
    logic             rsp_oob_q, rsp_oob_d;
    logic [7:0]       cpu_dout_q, cpu_dout_d;
    logic [7:0]       dma_dout_q, dma_dout_d;
    logic [15:0]      ram_addr_q, ram_addr_d;
    logic [7:0]       ram_din_q, ram_din_d;

    logic             steal;
    logic             grant_cpu;
    logic             grant_dma;
    logic             cpu_oob;
    logic             dma_oob;
    logic             sel_we;
    logic             sel_oob;
    logic [7:0]       rsp_data;

    // Out-of-range flags; these are constant zero unless bounds checking is built in.
    assign cpu_oob = BOUNDS_EN && (cpu_addr > RAM_TOP);
    assign dma_oob = BOUNDS_EN && (dma_addr > RAM_TOP);

    // Per-cycle arbitration and RAM port steering.
    // Reset blocks all grants so that no write can leak out while reset is held.
    always_comb begin
        steal     = (wait_cnt_q == CNT_MAX) && cpu_en;
        grant_cpu = cpu_en && !steal && !reset;
        grant_dma = !grant_cpu && dma_req && (state_q != ST_DMA_RSP) && !reset;

        ram_addr = ram_addr_q;
        ram_din  = ram_din_q;
        sel_we   = 1'b0;
        sel_oob  = 1'b0;
        if (grant_cpu) begin
            ram_addr = cpu_addr;
            ram_din  = cpu_din;
            sel_we   = cpu_we;
            sel_oob  = cpu_oob;
        end else if (grant_dma) begin
            ram_addr = dma_addr;
            ram_din  = dma_din;
            sel_we   = dma_we;
            sel_oob  = dma_oob;
        end
        ram_we  = sel_we && !sel_oob;
        cpu_rdy = !steal;
    end

    // Response side: route captured RAM data to whichever owner was granted last cycle.
    always_comb begin
        rsp_data   = rsp_oob_q ? 8'hFF : ram_dout;
        dma_ack    = (state_q == ST_DMA_RSP);
        cpu_dout   = cpu_dout_q;
        dma_dout   = dma_dout_q;
        cpu_dout_d = cpu_dout_q;
        if ((state_q == ST_CPU_RSP) && rsp_read_q) begin
            cpu_dout_d = rsp_data;
        end
        if ((state_q == ST_DMA_RSP) && rsp_read_q) begin
            dma_dout = rsp_data;
        end
        dma_dout_d = dma_dout;
    end

    // Next-state: response state follows the grant; the wait counter saturates while DMA is held off.
    always_comb begin
        state_d    = ST_IDLE;
        rsp_read_d = 1'b0;
        rsp_oob_d  = 1'b0;
        if (grant_cpu) begin
            state_d    = ST_CPU_RSP;
            rsp_read_d = !cpu_we;
            rsp_oob_d  = cpu_oob;
        end else if (grant_dma) begin
            state_d    = ST_DMA_RSP;
            rsp_read_d = !dma_we;
            rsp_oob_d  = dma_oob;
        end

        wait_cnt_d = '0;
        if (dma_req && !grant_dma) begin
            wait_cnt_d = (wait_cnt_q == CNT_MAX) ? wait_cnt_q : wait_cnt_q + 1'b1;
        end

        ram_addr_d = ram_addr;
        ram_din_d  = ram_din;
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= '0;
            rsp_read_q <= 1'b0;
            rsp_oob_q  <= 1'b0;
            cpu_dout_q <= 8'h00;
            dma_dout_q <= 8'h00;
            ram_addr_q <= 16'h0000;
            ram_din_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            rsp_read_q <= rsp_read_d;
            rsp_oob_q  <= rsp_oob_d;
            cpu_dout_q <= cpu_dout_d;
            dma_dout_q <= dma_dout_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Testbench for ram_arbiter: directed scenarios plus randomized traffic against a
// transaction-level reference (memory image + DMA wait accounting).
// Optional scenario enabled by RAM_BOUNDS_CHECK_EN.
module tb_ram_arbiter;

    localparam int LIMIT = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_en = 1'b0;
    logic [15:0] cpu_addr = '0;
    logic        cpu_we = 1'b0;
    logic [7:0]  cpu_din = '0;
    logic [7:0]  cpu_dout;
    logic        cpu_rdy;
    logic        dma_req = 1'b0;
    logic [15:0] dma_addr = '0;
    logic        dma_we = 1'b0;
    logic [7:0]  dma_din = '0;
    logic        dma_ack;
    logic [7:0]  dma_dout;
    logic [15:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout = '0;

    logic [7:0]  mem     [0:65535];
    logic [7:0]  ref_mem [0:65535];

    int n_cmp = 0;
    int n_bad = 0;

    ram_arbiter #(.STARVE_LIMIT(LIMIT), .RAM_TOP(16'hBFFF)) dut (
        .clk(clk), .reset(reset),
        .cpu_en(cpu_en), .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_din(cpu_din),
        .cpu_dout(cpu_dout), .cpu_rdy(cpu_rdy),
        .dma_req(dma_req), .dma_addr(dma_addr), .dma_we(dma_we), .dma_din(dma_din),
        .dma_ack(dma_ack), .dma_dout(dma_dout),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    // Behavioural single-port RAM with registered read (read returns pre-write data).
    always @(posedge clk) begin
        ram_dout <= mem[ram_addr];
        if (ram_we) mem[ram_addr] = ram_din;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached (got timeout, need finish)");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] init_byte(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        cpu_en = 1'b0; cpu_we = 1'b0; dma_req = 1'b0; dma_we = 1'b0;
    endtask

    task automatic reset_dut();
        tick(); reset = 1'b1; idle_inputs();
        tick(); tick(); reset = 1'b0;
    endtask

    task automatic test_reset();
        tick(); #1;
        n_cmp++; if (cpu_dout !== 8'h00) begin n_bad++; $display("FAIL reset_cpu_dout: got %h need 00", cpu_dout); end
        n_cmp++; if (dma_dout !== 8'h00) begin n_bad++; $display("FAIL reset_dma_dout: got %h need 00", dma_dout); end
        n_cmp++; if (dma_ack !== 1'b0) begin n_bad++; $display("FAIL reset_dma_ack: got %b need 0", dma_ack); end
        n_cmp++; if (cpu_rdy !== 1'b1) begin n_bad++; $display("FAIL reset_cpu_rdy: got %b need 1", cpu_rdy); end
        n_cmp++; if (ram_we !== 1'b0) begin n_bad++; $display("FAIL reset_ram_we: got %b need 0", ram_we); end
        reset = 1'b0;
        $display("test_reset: outputs checked during reset");
    endtask

    task automatic test_cpu_write_read();
        tick(); cpu_en = 1; cpu_we = 1; cpu_addr = 16'h0300; cpu_din = 8'h5A; #1;
        n_cmp++; if (ram_we !== 1'b1 || ram_addr !== 16'h0300 || ram_din !== 8'h5A) begin n_bad++; $display("FAIL cpu_wr_port: got we=%b addr=%h din=%h need we=1 addr=0300 din=5a", ram_we, ram_addr, ram_din); end
        tick(); cpu_we = 0; #1;
        n_cmp++; if (ram_we !== 1'b0 || ram_addr !== 16'h0300) begin n_bad++; $display("FAIL cpu_rd_port: got we=%b addr=%h need we=0 addr=0300", ram_we, ram_addr); end
        tick(); cpu_en = 0; #1;
        n_cmp++; if (cpu_dout !== 8'h00) begin n_bad++; $display("FAIL cpu_rd_early: got %h need 00 one cycle after read", cpu_dout); end
        tick(); #1;
        n_cmp++; if (cpu_dout !== 8'h5A) begin n_bad++; $display("FAIL cpu_rd_data: got %h need 5a", cpu_dout); end
        n_cmp++; if (mem[16'h0300] !== 8'h5A) begin n_bad++; $display("FAIL cpu_wr_mem: got %h need 5a", mem[16'h0300]); end
        $display("test_cpu_write_read: wrote 0300<=5a, read back %h", cpu_dout);
    endtask

    task automatic test_dma_write_read();
        tick(); dma_req = 1; dma_we = 1; dma_addr = 16'h1000; dma_din = 8'hA5; #1;
        n_cmp++; if (ram_we !== 1'b1 || ram_addr !== 16'h1000 || dma_ack !== 1'b0) begin n_bad++; $display("FAIL dma_wr_grant: got we=%b addr=%h ack=%b need we=1 addr=1000 ack=0", ram_we, ram_addr, dma_ack); end
        tick(); #1;
        n_cmp++; if (dma_ack !== 1'b1 || ram_we !== 1'b0) begin n_bad++; $display("FAIL dma_wr_ack: got ack=%b we=%b need ack=1 we=0", dma_ack, ram_we); end
        dma_req = 0;
        tick(); #1;
        n_cmp++; if (dma_ack !== 1'b0) begin n_bad++; $display("FAIL dma_ack_pulse: got %b need 0", dma_ack); end
        dma_req = 1; dma_we = 0; dma_addr = 16'h1000;
        tick(); #1;
        n_cmp++; if (dma_ack !== 1'b1 || dma_dout !== 8'hA5) begin n_bad++; $display("FAIL dma_rd: got ack=%b dout=%h need ack=1 dout=a5", dma_ack, dma_dout); end
        dma_req = 0;
        tick(); #1;
        n_cmp++; if (dma_ack !== 1'b0 || dma_dout !== 8'hA5) begin n_bad++; $display("FAIL dma_rd_hold: got ack=%b dout=%h need ack=0 dout=a5", dma_ack, dma_dout); end
        $display("test_dma_write_read: wrote 1000<=a5, read back %h", dma_dout);
    endtask

    task automatic test_starvation();
        int stolen_at = -1;
        int steals = 0;
        int ack_at = -1;
        int acks = 0;
        logic [7:0] got = 8'h00;
        for (int i = 0; i < 14; i++) begin
            tick();
            cpu_en = 1; cpu_we = 1; cpu_addr = 16'h2000 + 16'(i); cpu_din = 8'(i + 1);
            dma_req = (acks == 0); dma_we = 0; dma_addr = 16'h1000;
            #1;
            if (!cpu_rdy) begin steals++; if (stolen_at < 0) stolen_at = i; end
            if (dma_ack) begin acks++; ack_at = i; got = dma_dout; dma_req = 0; end
        end
        tick(); idle_inputs(); tick(); #1;
        n_cmp++; if (stolen_at !== LIMIT || steals !== 1) begin n_bad++; $display("FAIL starve_steal: got slot=%0d count=%0d need slot=%0d count=1", stolen_at, steals, LIMIT); end
        n_cmp++; if (ack_at !== LIMIT + 1 || acks !== 1 || got !== 8'hA5) begin n_bad++; $display("FAIL starve_ack: got slot=%0d count=%0d data=%h need slot=%0d count=1 data=a5", ack_at, acks, got, LIMIT + 1); end
        n_cmp++; if (mem[16'h2008] !== init_byte(16'h2008)) begin n_bad++; $display("FAIL starve_wr_suppressed: got %h need %h", mem[16'h2008], init_byte(16'h2008)); end
        n_cmp++; if (mem[16'h2007] !== 8'h08 || mem[16'h2009] !== 8'h0A) begin n_bad++; $display("FAIL starve_neighbours: got %h/%h need 08/0a", mem[16'h2007], mem[16'h2009]); end
        $display("test_starvation: steal at slot %0d, ack at slot %0d", stolen_at, ack_at);
    endtask

    task automatic test_simultaneous();
        tick(); cpu_en = 1; cpu_we = 0; cpu_addr = 16'h0300; dma_req = 1; dma_we = 0; dma_addr = 16'h1000; #1;
        n_cmp++; if (ram_addr !== 16'h0300 || cpu_rdy !== 1'b1) begin n_bad++; $display("FAIL simul_cpu_wins: got addr=%h rdy=%b need addr=0300 rdy=1", ram_addr, cpu_rdy); end
        tick(); cpu_en = 0; #1;
        n_cmp++; if (ram_addr !== 16'h1000 || dma_ack !== 1'b0) begin n_bad++; $display("FAIL simul_dma_next: got addr=%h ack=%b need addr=1000 ack=0", ram_addr, dma_ack); end
        tick(); #1;
        n_cmp++; if (dma_ack !== 1'b1 || dma_dout !== 8'hA5 || cpu_dout !== 8'h5A) begin n_bad++; $display("FAIL simul_data: got ack=%b dma=%h cpu=%h need ack=1 dma=a5 cpu=5a", dma_ack, dma_dout, cpu_dout); end
        dma_req = 0;
        $display("test_simultaneous: cpu=%h dma=%h", cpu_dout, dma_dout);
    endtask

    task automatic test_reset_mid_access();
        tick(); dma_req = 1; dma_we = 1; dma_addr = 16'h1100; dma_din = 8'hC3; #1;
        n_cmp++; if (ram_we !== 1'b1) begin n_bad++; $display("FAIL rstmid_grant: got we=%b need 1", ram_we); end
        #1 reset = 1'b1; #1;
        n_cmp++; if (ram_we !== 1'b0 || dma_ack !== 1'b0) begin n_bad++; $display("FAIL rstmid_immediate: got we=%b ack=%b need 0/0", ram_we, dma_ack); end
        tick(); dma_req = 0; #1;
        n_cmp++; if (dma_ack !== 1'b0 || cpu_dout !== 8'h00 || dma_dout !== 8'h00 || cpu_rdy !== 1'b1) begin n_bad++; $display("FAIL rstmid_outputs: got ack=%b cpu=%h dma=%h rdy=%b need 0/00/00/1", dma_ack, cpu_dout, dma_dout, cpu_rdy); end
        n_cmp++; if (mem[16'h1100] !== init_byte(16'h1100)) begin n_bad++; $display("FAIL rstmid_no_write: got %h need %h", mem[16'h1100], init_byte(16'h1100)); end
        reset = 1'b0;
        tick(); #1;
        n_cmp++; if (dma_ack !== 1'b0) begin n_bad++; $display("FAIL rstmid_late_ack: got %b need 0", dma_ack); end
        $display("test_reset_mid_access: aborted dma write checked");
    endtask

`ifdef RAM_BOUNDS_CHECK_EN
    task automatic test_bounds();
        tick(); cpu_en = 1; cpu_we = 1; cpu_addr = 16'hC000; cpu_din = 8'h11; #1;
        n_cmp++; if (ram_we !== 1'b0 || cpu_rdy !== 1'b1) begin n_bad++; $display("FAIL bounds_wr: got we=%b rdy=%b need 0/1", ram_we, cpu_rdy); end
        tick(); cpu_we = 0;
        tick(); cpu_en = 0;
        tick(); #1;
        n_cmp++; if (cpu_dout !== 8'hFF || mem[16'hC000] !== init_byte(16'hC000)) begin n_bad++; $display("FAIL bounds_rd: got dout=%h mem=%h need ff/%h", cpu_dout, mem[16'hC000], init_byte(16'hC000)); end
        $display("test_bounds: out-of-range read returned %h", cpu_dout);
    endtask
`endif

    task automatic test_random();
        int wait_cnt = 0;
        bit ack_now = 0, ack_read = 0, cpu_rsp_rd = 0, dma_pend = 0, cpu_retry = 0;
        bit exp_steal, g_cpu, g_dma, exp_we;
        logic [7:0] ack_data = '0, cpu_rsp_data = '0, exp_cpu_dout = '0, exp_dma_dout = '0;
        logic [15:0] exp_addr;
        int steals = 0, acks = 0, start_bad;
        reset_dut();
        for (int i = 0; i < 65536; i++) ref_mem[i] = mem[i];
        start_bad = n_bad;
        for (int c = 0; c < 1200; c++) begin
            tick();
            if (ack_now) dma_pend = 0;
            else if (!dma_pend && $urandom_range(0, 2) == 0) begin
                dma_pend = 1; dma_addr = 16'($urandom_range(0, 31)); dma_we = 1'($urandom_range(0, 1)); dma_din = 8'($urandom);
            end
            dma_req = dma_pend;
            if (!cpu_retry) begin
                cpu_en = ($urandom_range(0, 99) < (((c / 150) % 2 == 1) ? 97 : 55));
                cpu_addr = 16'($urandom_range(0, 31)); cpu_we = 1'($urandom_range(0, 1)); cpu_din = 8'($urandom);
            end
            #1;
            exp_steal = cpu_en && (wait_cnt == LIMIT);
            g_cpu = cpu_en && !exp_steal;
            g_dma = !g_cpu && dma_req && !ack_now;
            exp_we = (g_cpu && cpu_we) || (g_dma && dma_we);
            exp_addr = g_cpu ? cpu_addr : dma_addr;
            if (ack_now && ack_read) exp_dma_dout = ack_data;
            n_cmp++; if (cpu_rdy !== !exp_steal) begin n_bad++; $display("FAIL rnd_cpu_rdy c=%0d: got %b need %b", c, cpu_rdy, !exp_steal); end
            n_cmp++; if (dma_ack !== ack_now) begin n_bad++; $display("FAIL rnd_dma_ack c=%0d: got %b need %b", c, dma_ack, ack_now); end
            n_cmp++; if (dma_dout !== exp_dma_dout) begin n_bad++; $display("FAIL rnd_dma_dout c=%0d: got %h need %h", c, dma_dout, exp_dma_dout); end
            n_cmp++; if (cpu_dout !== exp_cpu_dout) begin n_bad++; $display("FAIL rnd_cpu_dout c=%0d: got %h need %h", c, cpu_dout, exp_cpu_dout); end
            n_cmp++; if (ram_we !== exp_we) begin n_bad++; $display("FAIL rnd_ram_we c=%0d: got %b need %b", c, ram_we, exp_we); end
            if (g_cpu || g_dma) begin
                n_cmp++; if (ram_addr !== exp_addr) begin n_bad++; $display("FAIL rnd_ram_addr c=%0d: got %h need %h", c, ram_addr, exp_addr); end
            end
            if (exp_steal) steals++;
            if (ack_now) acks++;
            // Advance the reference by one clock.
            if (cpu_rsp_rd) exp_cpu_dout = cpu_rsp_data;
            cpu_rsp_rd = g_cpu && !cpu_we; cpu_rsp_data = ref_mem[cpu_addr];
            ack_now = g_dma; ack_read = g_dma && !dma_we; ack_data = ref_mem[dma_addr];
            if (g_cpu && cpu_we) ref_mem[cpu_addr] = cpu_din;
            if (g_dma && dma_we) ref_mem[dma_addr] = dma_din;
            wait_cnt = (dma_req && !g_dma) ? ((wait_cnt < LIMIT) ? wait_cnt + 1 : LIMIT) : 0;
            cpu_retry = exp_steal;
        end
        tick(); idle_inputs(); tick(); tick();
        n_cmp++; if (steals == 0) begin n_bad++; $display("FAIL rnd_steal_seen: got 0 steals need >0"); end
        begin
            int diffs = 0;
            for (int a = 0; a < 32; a++) if (mem[a] !== ref_mem[a]) diffs++;
            n_cmp++; if (diffs != 0) begin n_bad++; $display("FAIL rnd_mem_image: got %0d differing bytes need 0", diffs); end
        end
        $display("test_random: 1200 cycles, %0d steals, %0d dma acks, %0d new mismatches", steals, acks, n_bad - start_bad);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = init_byte(16'(i));
        test_reset();
        test_cpu_write_read();
        test_dma_write_read();
        test_starvation();
        test_simultaneous();
        test_reset_mid_access();
`ifdef RAM_BOUNDS_CHECK_EN
        test_bounds();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
